// File: rtl/i2s_pkg.sv
// ============================================================================
// Module      : i2s_pkg
// Description : Shared types and constants for the I2S receive framer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2s_pkg;

    localparam int SAMPLE_BITS_DEF = 24;
    localparam int CNT_W           = $clog2(SAMPLE_BITS_DEF + 1);

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        SHIFT      = 2'd1,
        IDLE       = 2'd2
    } state_t;

    // Bit counter width for an arbitrary sample length (counts 0..bits).
    function automatic int cnt_width(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
// Module      : sync_edge
// Description : Multi-flop synchroniser with optional rising-edge detect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge #(
    parameter int STAGES   = 2,
    parameter bit EDGE_DET = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign o_level = r_sync[STAGES-1];

    generate
        if (EDGE_DET) begin : g_edge
            logic r_prev;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_prev <= 1'b0;
                end else begin
                    r_prev <= o_level;
                end
            end

            assign o_rise = o_level & ~r_prev;
        end else begin : g_no_edge
            assign o_rise = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/i2s_rx_framer.sv
// ============================================================================
// Module      : i2s_rx_framer
// Description : Oversampled I2S receiver; emits one left-justified sample per
//               slot with a single-cycle ce strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_rx_framer
    import i2s_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SAMPLE_BITS = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bclk,
    input  logic              lrclk,
    input  logic              sdin,
    output logic [DATA_W-1:0] dout,
    output logic              ce,
    output logic              chan,
    output logic              err
);

    localparam int                 c_cnt_w = cnt_width(SAMPLE_BITS);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(SAMPLE_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic w_bclk_s;
    logic w_bclk_rise;
    logic w_lr_s;
    logic w_sd_s;
    logic w_lr_rise_unused;
    logic w_sd_rise_unused;

    sync_edge #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sync_bclk (
        .clk     (clk),
        .rst     (rst),
        .i_async (bclk),
        .o_level (w_bclk_s),
        .o_rise  (w_bclk_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_sync_lr (
        .clk     (clk),
        .rst     (rst),
        .i_async (lrclk),
        .o_level (w_lr_s),
        .o_rise  (w_lr_rise_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_sync_sd (
        .clk     (clk),
        .rst     (rst),
        .i_async (sdin),
        .o_level (w_sd_s),
        .o_rise  (w_sd_rise_unused)
    );

    state_t                   r_state;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [SAMPLE_BITS-2:0]   r_shreg;
    logic                     r_lr_prev;
    logic                     r_lr_valid;
    logic                     r_slot_ch;
    logic [DATA_W-1:0]        r_dout;
    logic                     r_ce;
    logic                     r_chan;
    logic                     r_err;

    logic                     w_slot_start;
    logic [SAMPLE_BITS-1:0]   w_word;
    logic [DATA_W-1:0]        w_dout_just;

    assign w_slot_start = r_lr_valid & (w_lr_s != r_lr_prev);
    assign w_word       = {r_shreg, w_sd_s};
    // Left-justify: captured bits occupy the top of dout, low bits zero.
    assign w_dout_just  = DATA_W'(w_word) << (DATA_W - SAMPLE_BITS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= WAIT_FRAME;
            r_cnt      <= '0;
            r_shreg    <= '0;
            r_lr_prev  <= 1'b0;
            r_lr_valid <= 1'b0;
            r_slot_ch  <= CH_LEFT;
            r_dout     <= '0;
            r_ce       <= 1'b0;
            r_chan     <= CH_LEFT;
            r_err      <= 1'b0;
        end else begin
            r_ce  <= 1'b0;
            r_err <= 1'b0;
            if (w_bclk_rise) begin
                r_lr_prev  <= w_lr_s;
                r_lr_valid <= 1'b1;
                // The slot_start rise carries the previous slot's LSB and is dropped.
                case (r_state)
                    WAIT_FRAME, IDLE: begin
                        if (w_slot_start) begin
                            r_state   <= SHIFT;
                            r_cnt     <= '0;
                            r_shreg   <= '0;
                            r_slot_ch <= w_lr_s;
                        end
                    end
                    SHIFT: begin
                        if (w_slot_start) begin
                            r_err     <= 1'b1;
                            r_cnt     <= '0;
                            r_shreg   <= '0;
                            r_slot_ch <= w_lr_s;
                        end else if (r_cnt == c_last) begin
                            r_dout  <= w_dout_just;
                            r_chan  <= r_slot_ch;
                            r_ce    <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_shreg <= w_word[SAMPLE_BITS-2:0];
                            r_cnt   <= r_cnt + c_one;
                        end
                    end
                    default: begin
                        r_state <= WAIT_FRAME;
                    end
                endcase
            end
        end
    end

    assign dout = r_dout;
    assign ce   = r_ce;
    assign chan = r_chan;
    assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_i2s_rx_framer.sv
// ============================================================================
// Module      : tb_i2s_rx_framer
// Description : Self-checking bench for i2s_rx_framer (24-bit samples, 8x clk).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_rx_framer;

    logic        clk;
    logic        rst;
    logic        bclk;
    logic        lrclk;
    logic        sdin;
    logic [31:0] dout;
    logic        ce;
    logic        chan;
    logic        err;

    i2s_rx_framer #(
        .DATA_W      (32),
        .SAMPLE_BITS (24),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bclk  (bclk),
        .lrclk (lrclk),
        .sdin  (sdin),
        .dout  (dout),
        .ce    (ce),
        .chan  (chan),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dout_msb_chan;
        logic [31:0] dout;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        ch;
        logic [23:0] data;
        int          nrise;
        bit          exp_ce;
        int          exp_err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[14];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int err_cnt  = 0;
    logic prev_ce  = 1'b0;
    logic prev_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every ce and checks strobe shape.
    always @(negedge clk) begin
        if (ce) begin
            n_checks += 2;
            if (err) begin
                n_fail++;
                $display("FAIL ce_err_excl: ce=1 err=%0b, required err=0", err);
            end
            if (prev_ce) begin
                n_fail++;
                $display("FAIL ce_width: ce high two cycles at cyc %0d, required 1-cycle pulse", cyc);
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ce: ce with dout=%h chan=%0b at cyc %0d, required no ce", dout, chan, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_checks += 2;
                if (dout !== e.dout || chan !== e.dout_msb_chan) begin
                    n_fail++;
                    $display("FAIL sample: dout=%h chan=%0b, required dout=%h chan=%0b", dout, chan, e.dout, e.dout_msb_chan);
                end
                if (cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL latency: ce at cyc %0d, required cyc %0d", cyc, e.cyc);
                end
            end
        end
        if (err) begin
            err_cnt++;
            n_checks++;
            if (prev_err) begin
                n_fail++;
                $display("FAIL err_width: err high two cycles at cyc %0d, required 1-cycle pulse", cyc);
            end
        end
        prev_ce  <= ce;
        prev_err <= err;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // One bit period: data/ws change while bclk low, sampled on the rise.
    // Samples leave the synchronisers and FSM three clk after the rise is driven.
    task automatic bit_rise(input logic ch, input logic sd, input bit push, input logic [31:0] exp_d);
        bclk  = 1'b0;
        lrclk = ch;
        sdin  = sd;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        if (push) sb.push_back('{dout_msb_chan: ch, dout: exp_d, cyc: cyc + 3});
        repeat (4) @(negedge clk);
    endtask

    // Slot = one ws-change rise followed by nrise data rises (MSB first).
    task automatic send_slot(input logic ch, input logic [23:0] data, input int nrise, input bit expect_ce);
        for (int i = 0; i <= nrise; i++) begin
            logic sd;
            if (i >= 1 && i <= 24) sd = data[24-i];
            else                   sd = 1'($urandom_range(0, 1));
            bit_rise(ch, sd, expect_ce && (i == 24), {data, 8'h00});
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int e0;
        e0 = err_cnt;
        send_slot(v.ch, v.data, v.nrise, v.exp_ce);
        check($sformatf("err_count[%0d]", idx), 32'(err_cnt - e0), 32'(v.exp_err));
        check($sformatf("sb_drained[%0d]", idx), 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int e0;

        vecs[0]  = '{1'b1, 24'h777777, 12, 1'b0, 0};  // reset released mid right slot
        vecs[1]  = '{1'b0, 24'hABCDEF, 31, 1'b1, 0};
        vecs[2]  = '{1'b1, 24'h123456, 31, 1'b1, 0};
        vecs[3]  = '{1'b0, 24'h5A5A5A, 10, 1'b0, 0};  // short slot
        vecs[4]  = '{1'b1, 24'h00FFFF, 31, 1'b1, 1};  // err at its start
        vecs[5]  = '{1'b0, 24'h000001, 24, 1'b1, 0};  // exact-fit frames
        vecs[6]  = '{1'b1, 24'h800000, 24, 1'b1, 0};
        vecs[7]  = '{1'b0, 24'hFFFFFF, 24, 1'b1, 0};
        vecs[8]  = '{1'b1, 24'h000000, 24, 1'b1, 0};
        vecs[9]  = '{1'b0, 24'hA5A5A5, 24, 1'b1, 0};
        vecs[10] = '{1'b1, 24'h5A5A5A, 24, 1'b1, 0};
        vecs[11] = '{1'b0, 24'h13579B, 24, 1'b1, 0};
        vecs[12] = '{1'b1, 24'hFEDCBA, 24, 1'b1, 0};
        vecs[13] = '{1'b0, 24'h800001, 31, 1'b1, 0};

        rst   = 1'b1;
        bclk  = 1'b0;
        lrclk = 1'b0;
        sdin  = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_dout", dout, 32'h0);
        check("reset_ce",   {31'd0, ce},   32'h0);
        check("reset_chan", {31'd0, chan}, 32'h0);
        check("reset_err",  {31'd0, err},  32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Reset in the middle of a word: partial capture dropped, outputs cleared.
        e0 = err_cnt;
        send_slot(1'b1, 24'h654321, 12, 1'b0);
        bclk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_dout", dout, 32'h0);
        check("midrst_ce",   {31'd0, ce},   32'h0);
        check("midrst_chan", {31'd0, chan}, 32'h0);
        check("midrst_err",  {31'd0, err},  32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_slot(1'b1, 24'h111111, 31, 1'b0);
        send_slot(1'b0, 24'hC3A55A, 31, 1'b1);
        send_slot(1'b1, 24'h0F0F0F, 31, 1'b1);
        check("midrst_err_count", 32'(err_cnt - e0), 32'd0);
        repeat (10) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2s_rx_framer.md
Name: i2s_rx_framer

Overview:
- Upstream front-end of the audio effects datapath.
- Deserialises an external I2S stream (BCLK/LRCLK/SDIN), which is oversampled by the fabric clock.
- Delivers one left-justified 32-bit sample per slot with a single-cycle clock-enable strobe.
- Its dout/ce pair drives the filter stage's dp1/ce1 inputs directly.

Parameters:
- DATA_W, 32: width of dout. Must be ≥ SAMPLE_BITS.
- SAMPLE_BITS, 24: bits captured per slot, MSB first. Range 8..DATA_W.
- SYNC_STAGES, 2: flip-flop depth of the input synchronisers. Must be ≥ 2.

Ports:
- clk  in  1  fabric clock; must be ≥ 4× BCLK frequency.
- rst  in  1  synchronous, active-high reset.
- bclk  in  1  I2S bit clock; asynchronous to clk.
- lrclk  in  1  I2S word select: 0 = left, 1 = right; asynchronous.
- sdin  in  1  I2S serial data; asynchronous.
- dout  out  DATA_W  captured sample, left-justified, low bits zero.
- ce  out  1  one-clk strobe; dout and chan are valid while ce = 1.
- chan  out  1  channel of the sample currently in dout.
- err  out  1  one-clk pulse on a short-slot framing error.

Interface (already decided): one clock, clk. Reset rst is synchronous and active-high. All outputs are registered on clk.

Behaviour:
- Synchronisers:
  - bclk, lrclk and sdin each pass through SYNC_STAGES flip-flops.
  - bclk_rise is asserted for one clk when synchronised bclk goes 0→1.
  - All other logic acts only in cycles where bclk_rise = 1.
- On each bclk_rise:
  - Sample lr_s (synchronised lrclk) and sd_s (synchronised sdin).
  - Keep lr_prev = lr_s from the previous rise.
  - slot_start = (lr_s != lr_prev) and lr_prev is valid.
  - lr_prev is invalid after reset until the first rise.
- I2S framing: the rise on which slot_start is seen carries the previous slot's LSB and is discarded. The MSB arrives on the next rise.
- FSM states:
  - WAIT_FRAME (reset state): on slot_start, go to SHIFT with cnt = 0 and slot_ch = lr_s.
  - SHIFT: on each non-start rise, shreg = {shreg, sd_s} and cnt++. When the bit with cnt = SAMPLE_BITS−1 is captured:
    - load dout = {captured bits, (DATA_W−SAMPLE_BITS) zeros};
    - set chan = slot_ch and ce = 1 for the next clk;
    - go to IDLE.
  - SHIFT, slot_start with cnt < SAMPLE_BITS:
    - err = 1 for one clk;
    - discard the partial word; no ce;
    - restart SHIFT with cnt = 0 and slot_ch = lr_s.
  - IDLE: ignore bits until slot_start, then go to SHIFT with cnt = 0 and slot_ch = lr_s.
- Latency: ce is asserted in the clk following the bclk_rise cycle that captured the final bit.
- ce and err are never high for more than one consecutive clk. They cannot both be asserted in the same clk.
- dout and chan hold their values between strobes.
- Slot length equal to SAMPLE_BITS (no padding): the next slot_start lands in IDLE. This is legal, no err.
- Slot longer than SAMPLE_BITS: the extra bits are ignored in IDLE.
- Reset values: dout = 0, ce = 0, chan = 0, err = 0, state = WAIT_FRAME, cnt = 0, shreg = 0, lr_prev invalid. Synchroniser flops reset to 0.
- Reset mid-word: any partial capture is lost. No ce or err is issued for it. After release the block resynchronises on the next slot_start.
- No back-pressure: the downstream stage must accept every ce.

Decomposition:
- Package i2s_pkg holds:
  - the FSM state enum {WAIT_FRAME, SHIFT, IDLE};
  - localparam CNT_W = $clog2(SAMPLE_BITS+1);
  - the channel constants CH_LEFT = 0 and CH_RIGHT = 1.
- One natural sub-module, sync_edge:
  - parameterised synchroniser chain with rise detect;
  - instantiated for bclk (with edge detect) and for lrclk and sdin (synchronised level only).

Test Plan (SAMPLE_BITS = 24, DATA_W = 32, 32-bit slots, clk = 8× BCLK):
- Stereo frame: left 0xABCDEF, right 0x123456 → ce with dout = 0xABCDEF00, chan = 0; then ce with dout = 0x12345600, chan = 1; err never asserted.
- Startup mid-slot: release rst partway through a right slot → no ce until the next left slot completes; first output is dout = left data, chan = 0.
- Short slot: lrclk toggles after only 10 bits of a left slot → err pulses once, no ce; the following right slot 0x00FFFF yields dout = 0x00FFFF00, chan = 1.
- Exact-fit slots of 24 bits with no padding, 4 consecutive frames → 8 ce strobes, no err.
- Reset asserted mid-SHIFT for 3 clk → outputs return to 0 within 1 clk; no stale ce; the next complete slot is captured correctly.
- Latency check: ce rises exactly 1 clk after the bclk_rise cycle capturing bit 24. Each ce is exactly 1 clk wide, with ce/err mutually exclusive throughout.
